// File: rtl/uart_rx_deserializer.sv
// 8N1 serial receiver: synchronises rx, rejects start-bit glitches, checks the
// stop bit and parks in BREAK while the line stays low after a framing error.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF         = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] rxData,
    output logic       rxReady,
    output logic       frameError,
    output logic       busy
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t           state, state_n;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [7:0]       sh, sh_n;
    logic [7:0]       data_n;
    logic             ready_n, ferr_n, busy_n;

    // Two-flop synchroniser; s2 is the only view of rx used below.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= rx;
            s2 <= s1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            rxData     <= '0;
            rxReady    <= 1'b0;
            frameError <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            sh         <= sh_n;
            rxData     <= data_n;
            rxReady    <= ready_n;
            frameError <= ferr_n;
            busy       <= busy_n;
        end
    end

    // Next-state, bit timing and output pulses.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        data_n  = rxData;
        ready_n = 1'b0;
        ferr_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!s2) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (s2) begin
                        state_n = ST_IDLE;
                    end else begin
                        idx_n   = '0;
                        state_n = ST_DATA;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    sh_n  = {s2, sh[7:1]};
                    if (idx == IDX_LAST) state_n = ST_STOP;
                    else                 idx_n   = idx + IDX_W'(1);
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (s2) begin
                        data_n  = sh;
                        ready_n = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = ST_BREAK;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                cnt_n = '0;
                if (s2) state_n = ST_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: frames are scored by sampling the transmitted
// waveform at the receiver's nominal sample instants; a monitor checks each pulse.
module tb_uart_rx_deserializer;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // rx changes just after posedge P; the stop-bit decision is visible after edge P+LAT.
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] rxData;
    logic       rxReady;
    logic       frameError;
    logic       busy;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .rxData     (rxData),
        .rxReady    (rxReady),
        .frameError (frameError),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Level seen at each nominal sample instant of a frame sent at 'rate' cycles/bit.
    // Returns {stop_level, byte}.
    function automatic logic [8:0] model_frame(input logic [7:0] d, input int rate,
                                               input bit stop, input bit after);
        logic [7:0] b;
        logic       st;
        logic       lvl;
        int         j, w;
        b  = '0;
        st = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            j = HALF + m * CPB;
            w = j / rate;
            if (w == 0)      lvl = 1'b0;
            else if (w <= 8) lvl = d[w-1];
            else if (w == 9) lvl = stop;
            else             lvl = after;
            if (m <= 8) b[m-1] = lvl;
            else        st     = lvl;
        end
        return {st, b};
    endfunction

    // Must be called just after a posedge; returns just after a posedge.
    task automatic send_frame(input logic [7:0] d, input int rate, input bit stop,
                              input int hold_low, input int gap);
        int         c0;
        logic [8:0] r;
        exp_t       e;
        bit         after;
        c0    = cyc;
        after = stop ? 1'b1 : (hold_low > 0 ? 1'b0 : 1'b1);
        r     = model_frame(d, rate, stop, after);
        if (r[8]) begin
            last_good = r[7:0];
            e = '{1'b0, r[7:0], c0 + LAT};
        end else begin
            e = '{1'b1, last_good, c0 + LAT};
        end
        sb.push_back(e);
        for (int i = 0; i < 10; i++) begin
            rx = (i == 0) ? 1'b0 : (i == 9) ? stop : d[i-1];
            repeat (rate) @(posedge clk);
            #1;
        end
        if (hold_low > 0) begin
            rx = 1'b0;
            repeat (hold_low) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        int   sel;
        int   rate;
        int   gap;

        // Monitor: every pulse must match the head of the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (rstn && (rxReady || frameError)) begin
                    check("pulse_exclusive", 32'(rxReady & frameError), 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse @cyc %0d: got rxReady=%0b frameError=%0b expected none",
                                 cyc, rxReady, frameError);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_kind", 32'(frameError), 32'(e.is_err));
                        check("pulse_data", 32'(rxData), 32'(e.data));
                        check("pulse_cycle", 32'(cyc), 32'(e.at));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rxData", 32'(rxData), 32'h00);
        check("rst_rxReady", 32'(rxReady), 32'd0);
        check("rst_frameError", 32'(frameError), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(10);

        // Single byte at nominal rate
        send_frame(8'hA5, CPB, 1'b1, 0, 20);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, CPB, 1'b1, 0, 0);
        send_frame(8'hFF, CPB, 1'b1, 0, 0);
        send_frame(8'h55, CPB, 1'b1, 0, 20);

        // 5-cycle glitch on an idle line
        n  = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (i == 4) begin
                @(posedge clk);
                #1;
                rx = 1'b1;
            end
        end
        check("glitch_busy_len", 32'((n >= 1) && (n <= 10)), 32'd1);
        check("glitch_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Low stop bit followed by a long break
        send_frame(8'h3C, CPB, 1'b0, 400, 0);
        check("break_busy", 32'(busy), 32'd1);
        idle(10);
        check("break_exit", 32'(busy), 32'd0);
        check("break_data_held", 32'(rxData), 32'h55);
        send_frame(8'h81, CPB, 1'b1, 0, 20);

        // Reset in the middle of data bit 4 of 0x96
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            rx = 1'(8'h96 >> i);
            repeat ((i == 4) ? CPB / 2 : CPB) @(posedge clk);
            #1;
        end
        rstn = 1'b0;
        #1;
        check("midrst_rxData", 32'(rxData), 32'h00);
        check("midrst_rxReady", 32'(rxReady), 32'd0);
        check("midrst_frameError", 32'(frameError), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn      = 1'b1;
        last_good = 8'h00;
        idle(20);
        send_frame(8'h42, CPB, 1'b1, 0, 20);

        // Baud skew
        send_frame(8'hC3, CPB - 1, 1'b1, 0, 20);
        send_frame(8'hC3, CPB + 1, 1'b1, 0, 20);

        // Randomised traffic
        for (int k = 0; k < 24; k++) begin
            sel = int'($urandom_range(0, 5));
            gap = int'($urandom_range(0, 12));
            if (sel == 0) begin
                send_frame(8'($urandom), CPB, 1'b0, int'($urandom_range(0, 60)), gap + 4);
            end else begin
                rate = (sel == 1) ? CPB - 1 : (sel == 2) ? CPB + 1 : CPB;
                if (rate < CPB && gap < 4) gap = 4;
                send_frame(8'($urandom), rate, 1'b1, 0, gap);
            end
        end

        // Drain
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (5) @(posedge clk);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Serial-line receiver for the trigger board's host link. It converts the asynchronous 8N1 `rx` pin into byte strobes (`rxData`/`rxReady`) for the command processor. It sits directly upstream of that processor, which latches `rxData` on any cycle `rxReady` is high and never back-pressures. The block adds metastability hardening, start-bit glitch rejection, stop-bit framing checks and break handling.

## Interface
- `CLKS_PER_BIT`, default 434: `clk` cycles per bit (50 MHz / 115200). Legal range 8..65535.
- `HALF`, default `CLKS_PER_BIT/2` (integer division): delay to mid-start-bit.
- `clk  in  1`: single clock, 50 MHz; all logic on its rising edge.
- `rstn  in  1`: asynchronous, active-low reset.
- `rx  in  1`: raw serial line, idle high, asynchronous to `clk`.
- `rxData  out  8`: last good byte, LSB received first. Reset 0x00.
- `rxReady  out  1`: one-cycle pulse when `rxData` has just been updated. Reset 0.
- `frameError  out  1`: one-cycle pulse when the stop bit is sampled low. Reset 0.
- `busy  out  1`: high whenever state ≠ IDLE. Reset 0.

## Operation
- Synchronizer: two flops `s1 -> s2`, both reset to 1. `s2` is the only copy of `rx` used anywhere.
- Single bit-timer `cnt` (16 bit) and bit index `idx` (0..7). Shift register `sh[7:0]` shifts right; the new bit enters at `sh[7]`.
- States:
  - IDLE: `cnt` = 0. If `s2` = 0, go to START.
  - START: `cnt` increments.
    - When `cnt` = HALF-1, sample `s2`. If 1 (glitch), go to IDLE with no output pulse. If 0, set `cnt` = 0 and `idx` = 0 and go to DATA.
  - DATA: `cnt` increments.
    - When `cnt` = CLKS_PER_BIT-1, shift `s2` into `sh` and clear `cnt`.
    - If `idx` = 7, go to STOP; otherwise increment `idx`.
  - STOP: `cnt` increments. When `cnt` = CLKS_PER_BIT-1, sample `s2`:
    - 1: `rxData` <= `sh`, `rxReady` = 1 for that single cycle, go to IDLE.
    - 0: `frameError` = 1 for one cycle, `rxData` unchanged, go to BREAK.
  - BREAK: stay until `s2` = 1, then go to IDLE. Any length of low line produces exactly one `frameError` and no `rxReady`.
- Returning to IDLE at the stop-bit sample point allows a following start bit to be detected with no idle gap between frames.
- `rxReady` and `frameError` are never high in the same cycle.
- `rxData` holds its value between frames and after errors.
- Reset asserted mid-frame: every register returns to its reset value immediately. No pulse is emitted for the partial frame. After release, the block resynchronises at the next low `s2` seen in IDLE.
- Line held low through reset release: the block enters START 2 cycles after release, runs a full frame, emits one `frameError` and waits in BREAK.

## Timing
- Synchronizer latency is 2 cycles. Let E be the first rising `clk` edge at which `s1` captures `rx` = 0.
  - START entered at E+2.
  - Start sample at E+2+HALF.
  - Data bit k sampled at E+2+HALF+(k+1)·CLKS_PER_BIT, for k = 0..7.
  - Stop sample at E+2+HALF+9·CLKS_PER_BIT. `rxReady`/`frameError` are registered and visible in the cycle after that edge.
- Throughput is one byte per 10·CLKS_PER_BIT cycles. Tolerates ±4 % baud mismatch at CLKS_PER_BIT ≥ 16.
- `rxReady` is a registered output with no combinational path from `rx`.

## Test plan
- CLKS_PER_BIT = 16: send 0xA5 at exact rate -> `rxData` = 0xA5, `rxReady` high for exactly 1 cycle, 155 cycles after `rx` falls (aligned to a clk edge); `frameError` never high.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three `rxReady` pulses 160 cycles apart, `rxData` sequence 0x00, 0xFF, 0x55.
- 5-cycle low glitch on idle line -> no `rxReady`, no `frameError`, `busy` high for at most 10 cycles, then IDLE.
- Frame 0x3C with stop bit forced low, line then held low for 400 cycles -> one `frameError` pulse, `rxData` keeps previous 0x55, `busy` stays high until `rx` rises; the next 0x81 frame is received correctly.
- `rstn` pulsed low during data bit 4 of frame 0x96 -> all outputs 0 immediately; no pulse for 0x96; the next 0x42 frame yields `rxData` = 0x42.
- Baud skew: transmit 0xC3 at 15 and at 17 cycles/bit with CLKS_PER_BIT = 16 -> both received as 0xC3 with no `frameError`.
